sel_type_pipe: RTL and testbench
================================

# sel_type_pipe

Registered, parametrised successor to the combinational instruction-type selector in the core's decode path. Accepts raw 32-bit RV32I instructions over a valid/ready handshake, classifies each into an instruction format (R/I/S/B/U/J/illegal), generates the sign-extended immediate for that format, and buffers results in a DEPTH-entry FIFO toward the execute stage. Sits between instruction fetch and the register-file/ALU operand mux.

## Interface

- XLEN, default 32: width of the generated immediate (≥32; sign-extended above bit 31).
- DEPTH, default 2: output FIFO entries (power of two, 2..16).
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  in_instr is valid.
- in_ready  output  1  block can accept an instruction this cycle.
- in_instr  input  32  raw instruction.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer takes head entry.
- out_type  output  3  format: 000 R, 001 I, 010 S, 011 B, 100 U, 101 J, 111 illegal.
- out_imm  output  XLEN  sign-extended immediate (0 for R and illegal).
- out_instr  output  32  instruction passed through.
- ill_cnt  output  16  illegal-instruction count (only with SEL_TYPE_ILL_CNT_EN).

## Operation

- Opcode [6:0] map: 0110011→R; 0010011, 0000011, 1100111, 1110011→I; 0100011→S; 1100011→B; 0110111, 0010111→U; 1101111→J; all others→111.
- Immediates (sign bit = instr[31]): I {instr[31:20]}; S {instr[31:25],instr[11:7]}; B {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}; U {instr[31:12],12'b0}; J {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}.
- Decode is combinational on the input; the result {type, imm, instr} is written into the FIFO on accept (in_valid && in_ready).
- FIFO: write/read pointers of log2(DEPTH)+1 bits; full when low bits equal and MSBs differ, empty when pointers equal. Pointers wrap modulo 2·DEPTH.
- in_ready = !full (registered-state only; no dependence on out_ready).
- Pop on out_valid && out_ready. Push and pop in the same cycle are both performed when not full and not empty; occupancy unchanged.
- Push into an empty FIFO with simultaneous out_ready: no bypass; entry appears next cycle.
- flush: pointers reset to zero next edge; a push in the same cycle is dropped; a pop in the same cycle is ignored.
- Outputs out_type/out_imm/out_instr reflect the head entry; undefined-but-stable when out_valid=0 (reset value 0).

## Timing

- Latency: accept at edge N → out_valid=1 after edge N (visible in cycle N+1).
- Throughput: one instruction per cycle while consumer keeps out_ready=1.
- Reset (rst_n=0, async): in_ready=1, out_valid=0, out_type=000, out_imm=0, out_instr=0, ill_cnt=0; pointers zero. Reset mid-stream discards all entries.
- out_valid and head data hold stable while out_valid && !out_ready.

## Configuration

- SEL_TYPE_ILL_CNT_EN defined: ill_cnt port present; increments by 1 on each accepted instruction of type 111, saturates at 16'hFFFF, cleared only by rst_n (flush does not clear it).
- Undefined: ill_cnt port and counter absent; illegal instructions still buffered with type 111.

## Test plan

- Reset then push 0x00500093 (addi x1,x0,5) with out_ready=1 → next cycle out_valid=1, out_type=001, out_imm=0x00000005.
- Push 0x0020A223, 0xFE000EE3, 0x123450B7, 0x0080006F back-to-back → types 010/011/100/101, imm 0x4, 0xFFFFFFFC, 0x12345000, 0x8, in order, one per cycle.
- out_ready=0, push DEPTH=2 instructions → in_ready=0 after second accept; third in_valid held until out_ready=1, then FIFO order preserved, no loss/duplication.
- Fill FIFO, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, dropped instruction never appears.
- Push 0xFFFFFFFF three times (macro defined) → out_type=111, out_imm=0, ill_cnt=3; flush leaves ill_cnt=3; rst_n low clears to 0.
- Assert rst_n=0 asynchronously mid-stream with FIFO full → outputs at reset values immediately, before next clk edge.

Source files
------------

// File: rtl/sel_type_pipe_if.sv
// Fetch-to-execute handshake bundle for sel_type_pipe: instruction in, decoded entry out.
interface sel_type_pipe_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_type;
  logic [XLEN-1:0] out_imm;
  logic [31:0]     out_instr;

  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_type, out_imm, out_instr
  );
  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_type, out_imm, out_instr
  );
endinterface

// File: rtl/sel_type_pipe.sv
// RV32I format classifier + immediate generator feeding a DEPTH-entry FIFO.
// Optional illegal-instruction counter: define SEL_TYPE_ILL_CNT_EN.
module sel_type_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  sel_type_pipe_if.slave  bus
`ifdef SEL_TYPE_ILL_CNT_EN
  ,
  output logic [15:0]     ill_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]      typ;
    logic [XLEN-1:0] imm;
    logic [31:0]     instr;
  } entry_t;

  entry_t      dec;
  logic [31:0] imm32;
  entry_t      mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        full, empty, push, pop;

  always_comb begin
    imm32   = '0;
    dec.typ = 3'b111;
    unique case (bus.in_instr[6:0])
      7'b0110011: dec.typ = 3'b000;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec.typ = 3'b001;
        imm32   = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      end
      7'b0100011: begin
        dec.typ = 3'b010;
        imm32   = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
      end
      7'b1100011: begin
        dec.typ = 3'b011;
        imm32   = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                   bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.typ = 3'b100;
        imm32   = {bus.in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.typ = 3'b101;
        imm32   = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                   bus.in_instr[20], bus.in_instr[30:21], 1'b0};
      end
      default: dec.typ = 3'b111;
    endcase
    dec.imm   = XLEN'($signed(imm32));
    dec.instr = bus.in_instr;
  end

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push  = bus.in_valid && !full && !bus.flush;
  assign pop   = !empty && bus.out_ready && !bus.flush;

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_type  = mem[rptr[AW-1:0]].typ;
  assign bus.out_imm   = mem[rptr[AW-1:0]].imm;
  assign bus.out_instr = mem[rptr[AW-1:0]].instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (bus.flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr[AW-1:0]] <= dec;
    end
  end

`ifdef SEL_TYPE_ILL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ill_cnt <= '0;
    else if (push && dec.typ == 3'b111 && ill_cnt != 16'hFFFF)
      ill_cnt <= ill_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_sel_type_pipe.sv
// Randomized + directed bench for sel_type_pipe against a queue-based reference model.
module tb_sel_type_pipe;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  typedef struct {
    logic [2:0]      typ;
    logic [XLEN-1:0] imm;
    logic [31:0]     instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;
`ifdef SEL_TYPE_ILL_CNT_EN
  logic [15:0] ill_cnt;
`endif

  sel_type_pipe_if #(.XLEN(XLEN)) bus ();

  sel_type_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef SEL_TYPE_ILL_CNT_EN
    ,
    .ill_cnt(ill_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference decode: immediates assembled arithmetically from a sign-extended word.
  function automatic exp_t ref_dec(input logic [31:0] i);
    exp_t   e;
    longint s, v;
    s = longint'($signed(i));
    v = 0;
    case (i[6:0])
      7'h33:                      e.typ = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73: begin e.typ = 3'd1; v = s >>> 20; end
      7'h23: begin
        e.typ = 3'd2;
        v = ((s >>> 25) * 32) + longint'(i[11:7]);
      end
      7'h63: begin
        e.typ = 3'd3;
        v = ((s >>> 31) * 4096) + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
            + longint'(i[11:8]) * 2;
      end
      7'h37, 7'h17: begin e.typ = 3'd4; v = (s >>> 12) * 4096; end
      7'h6f: begin
        e.typ = 3'd5;
        v = ((s >>> 31) * 1048576) + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
            + longint'(i[30:21]) * 2;
      end
      default: e.typ = 3'd7;
    endcase
    e.imm   = XLEN'(v);
    e.instr = i;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_type !== 3'b000 ||
        bus.out_imm !== '0 || bus.out_instr !== '0)
      $display("FAIL reset: rdy=%b vld=%b type=%b imm=%h instr=%h, want 1 0 000 0 0",
               bus.in_ready, bus.out_valid, bus.out_type, bus.out_imm, bus.out_instr);
    else passed++;
`ifdef SEL_TYPE_ILL_CNT_EN
    total++;
    if (ill_cnt !== 16'd0) $display("FAIL reset_ill_cnt: got %0d want 0", ill_cnt);
    else passed++;
`endif
  endtask

  task automatic test_addi();
    bus.in_valid = 1'b1; bus.in_instr = 32'h0050_0093; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_type !== 3'b001 || bus.out_imm !== 32'h5)
      $display("FAIL addi: vld=%b type=%b imm=%h, want 1 001 00000005",
               bus.out_valid, bus.out_type, bus.out_imm);
    else passed++;
    tick();
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL addi_drain: vld=%b want 0", bus.out_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins  [4] = '{32'h0020_A223, 32'hFE00_0EE3, 32'h1234_50B7, 32'h0080_006F};
    logic [2:0]  typs [4] = '{3'b010, 3'b011, 3'b100, 3'b101};
    logic [31:0] imms [4] = '{32'h4, 32'hFFFF_FFFC, 32'h1234_5000, 32'h8};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1; bus.in_instr = ins[k];
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_type !== typs[k] || bus.out_imm !== imms[k] ||
          bus.out_instr !== ins[k])
        $display("FAIL b2b[%0d]: vld=%b type=%b imm=%h instr=%h, want 1 %b %h %h", k,
                 bus.out_valid, bus.out_type, bus.out_imm, bus.out_instr, typs[k], imms[k], ins[k]);
      else passed++;
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] ins [3] = '{32'h0000_0033, 32'h0040_0113, 32'h0000_0197};
    logic [31:0] got [$];
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1; bus.in_instr = ins[k];
      tick();
    end
    bus.in_instr = ins[2];
    total++;
    if (bus.in_ready !== 1'b0) $display("FAIL bp_full: in_ready=%b want 0", bus.in_ready);
    else passed++;
    tick(); tick();
    total++;
    if (bus.in_ready !== 1'b0 || bus.out_instr !== ins[0])
      $display("FAIL bp_hold: rdy=%b head=%h want 0 %h", bus.in_ready, bus.out_instr, ins[0]);
    else passed++;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid) got.push_back(bus.out_instr);
      if (bus.in_ready) begin
        tick();
        bus.in_valid = 1'b0;
      end else tick();
    end
    total++;
    if (got.size() != 3 || got[0] !== ins[0] || got[1] !== ins[1] || got[2] !== ins[2])
      $display("FAIL bp_order: got %0d entries, want 3 in order %h %h %h",
               got.size(), ins[0], ins[1], ins[2]);
    else passed++;
    idle();
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_valid = 1'b1; bus.in_instr = 32'h0000_0013 + (k << 20);
      tick();
    end
    bus.in_instr = 32'hABCD_E037;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL flush: vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
    else passed++;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    total++;
    if (seen !== 1'b0) $display("FAIL flush_drop: stale entry observed=%b want 0", seen);
    else passed++;
    idle();
  endtask

  task automatic test_illegal();
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; bus.in_instr = 32'hFFFF_FFFF;
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_type !== 3'b111 || bus.out_imm !== '0)
        $display("FAIL illegal[%0d]: vld=%b type=%b imm=%h want 1 111 0", k,
                 bus.out_valid, bus.out_type, bus.out_imm);
      else passed++;
    end
    bus.in_valid = 1'b0;
    tick();
`ifdef SEL_TYPE_ILL_CNT_EN
    total++;
    if (ill_cnt !== 16'd3) $display("FAIL ill_cnt: got %0d want 3", ill_cnt);
    else passed++;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    total++;
    if (ill_cnt !== 16'd3) $display("FAIL ill_cnt_flush: got %0d want 3", ill_cnt);
    else passed++;
    do_reset();
    total++;
    if (ill_cnt !== 16'd0) $display("FAIL ill_cnt_rst: got %0d want 0", ill_cnt);
    else passed++;
`endif
    idle();
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_valid = 1'b1; bus.in_instr = 32'hFFF0_0093;
      tick();
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_type !== 3'b000 ||
        bus.out_imm !== '0 || bus.out_instr !== '0)
      $display("FAIL async_reset: rdy=%b vld=%b type=%b imm=%h instr=%h want 1 0 000 0 0",
               bus.in_ready, bus.out_valid, bus.out_type, bus.out_imm, bus.out_instr);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6f, 7'h7f, 7'h0b};
    exp_t q [$];
    int   errs = 0;
    logic acc, deq;
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.in_instr  = {$urandom} & 32'hFFFF_FF80 | 32'(ops[$urandom_range(0, 11)]);
      #1;
      if (bus.in_ready !== (q.size() < DEPTH) || bus.out_valid !== (q.size() != 0)) errs++;
      else if (q.size() != 0 && (bus.out_type !== q[0].typ || bus.out_imm !== q[0].imm ||
                                 bus.out_instr !== q[0].instr)) errs++;
      acc = bus.in_valid && (q.size() < DEPTH);
      deq = bus.out_ready && (q.size() != 0);
      if (deq) void'(q.pop_front());
      if (acc) q.push_back(ref_dec(bus.in_instr));
      tick();
    end
    total++;
    if (errs != 0) $display("FAIL random: %0d cycle mismatches, want 0", errs);
    else passed++;
    idle();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #2 rst_n = 1'b0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_illegal();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
